// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - round-robin arbiter sharing one UART transmitter between NREQ byte sources
//
// Ports:
//   sys_clk    in   1        system clock
//   sys_rst    in   1        synchronous reset, active high
//   req        in   NREQ     req[i]=1: requester i offers the byte on req_data[8i+7:8i]
//   req_data   in   8*NREQ   flat byte bus, byte i stable while req[i]=1 and not yet acked
//   ack        out  NREQ     one-cycle pulse, byte i captured
//   uart_send  out  1        transmit start strobe, one cycle wide
//   tx_data    out  8        byte to UART, held from SEND until return to IDLE
//   busy       out  1        high whenever the sequencer is not IDLE
//   grant_id   out  GW       index of the current or last granted requester
module uart_tx_arb #(
  parameter int NREQ    = 4,
  parameter int BPS_CNT = 25,
  parameter int GUARD   = 4
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic [NREQ-1:0]          req,
  input  logic [8*NREQ-1:0]        req_data,
  output logic [NREQ-1:0]          ack,
  output logic                     uart_send,
  output logic [7:0]               tx_data,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  grant_id
);

  localparam int GW           = $clog2(NREQ);
  localparam int FRAME_CYCLES = 10 * BPS_CNT + GUARD;
  localparam int CW           = $clog2(FRAME_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            send_q, send_d;
  logic [7:0]      tx_q, tx_d;
  logic            busy_q, busy_d;
  logic [GW-1:0]   gnt_q, gnt_d;

  // Round-robin pick: search starts one past the last grant and wraps,
  // so the last winner is considered only after everyone else.
  logic            found;
  logic [GW-1:0]   win;
  always_comb begin
    found = 1'b0;
    win   = gnt_q;
    for (int k = 1; k <= NREQ; k++) begin
      int j;
      j = (int'(gnt_q) + k) % NREQ;
      if (!found && req[j]) begin
        found = 1'b1;
        win   = GW'(j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    send_d  = 1'b0;
    tx_d    = tx_q;
    busy_d  = busy_q;
    gnt_d   = gnt_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d    = ST_SEND;
          tx_d       = req_data[8*win +: 8];
          gnt_d      = win;
          ack_d[win] = 1'b1;
          send_d     = 1'b1;
          busy_d     = 1'b1;
        end
      end
      ST_SEND: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
        busy_d  = 1'b1;
      end
      ST_WAIT: begin
        // WAIT spans FRAME_CYCLES cycles; with the SEND and IDLE cycles the
        // grant period is FRAME_CYCLES+2.
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ack_q   <= '0;
      send_q  <= 1'b0;
      tx_q    <= 8'h00;
      busy_q  <= 1'b0;
      gnt_q   <= GW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      send_q  <= send_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      gnt_q   <= gnt_d;
    end
  end

  assign ack       = ack_q;
  assign uart_send = send_q;
  assign tx_data   = tx_q;
  assign busy      = busy_q;
  assign grant_id  = gnt_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - self-checking bench for uart_tx_arb
module tb_uart_tx_arb;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        uart_send;
  logic [7:0]  tx_data;
  logic        busy;
  logic [1:0]  grant_id;

  uart_tx_arb dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .uart_send (uart_send),
    .tx_data   (tx_data),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Invariants checked every cycle.
  logic       prev_send = 1'b0;
  logic       prev_busy = 1'b0;
  logic [7:0] prev_tx   = 8'h00;
  always @(negedge sys_clk) begin
    chk("ack_onehot0", {31'd0, $onehot0(ack)}, 32'd1);
    chk("send_adjacent", {31'd0, uart_send & prev_send}, 32'd0);
    if (busy && prev_busy) chk("tx_stable", {24'd0, tx_data}, {24'd0, prev_tx});
    prev_send = uart_send;
    prev_busy = busy;
    prev_tx   = tx_data;
  end

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [1:0]  exp_gnt;
    logic [7:0]  exp_byte;
  } vec_t;

  vec_t tbl [14];

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge sys_clk);
      if (ack != 4'b0000) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge sys_clk);
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bit ok;
    int last;
    int rst_cyc;

    // Grant history starts at 3 after reset.
    tbl[0]  = '{4'b0001, 32'hA3A2A155, 2'd0, 8'h55};
    tbl[1]  = '{4'b1111, 32'hA3A2A1A0, 2'd1, 8'hA1};
    tbl[2]  = '{4'b1111, 32'hA3A2A1A0, 2'd2, 8'hA2};
    tbl[3]  = '{4'b1111, 32'hA3A2A1A0, 2'd3, 8'hA3};
    tbl[4]  = '{4'b1111, 32'hA3A2A1A0, 2'd0, 8'hA0};
    tbl[5]  = '{4'b1010, 32'hA3A2A1A0, 2'd1, 8'hA1};
    tbl[6]  = '{4'b1010, 32'hA3A2A1A0, 2'd3, 8'hA3};
    tbl[7]  = '{4'b1010, 32'hA3A2A1A0, 2'd1, 8'hA1};
    tbl[8]  = '{4'b1010, 32'hA3A2A1A0, 2'd3, 8'hA3};
    tbl[9]  = '{4'b1010, 32'hA3A2A1A0, 2'd1, 8'hA1};
    tbl[10] = '{4'b0100, 32'hA3A2A1A0, 2'd2, 8'hA2};
    tbl[11] = '{4'b1001, 32'hA3A2A1A0, 2'd3, 8'hA3};
    tbl[12] = '{4'b1001, 32'hA3A2A1A0, 2'd0, 8'hA0};
    tbl[13] = '{4'b0110, 32'hA3A2A1A0, 2'd1, 8'hA1};

    sys_rst  = 1'b1;
    req      = 4'b0000;
    req_data = 32'h0;
    repeat (3) @(negedge sys_clk);
    chk("rst_ack", {28'd0, ack}, 32'd0);
    chk("rst_send", {31'd0, uart_send}, 32'd0);
    chk("rst_tx", {24'd0, tx_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_gnt", {30'd0, grant_id}, 32'd3);
    sys_rst = 1'b0;

    // Table: each request is re-offered right after the previous ack, so
    // grants should land exactly one grant period apart.
    last = 0;
    for (int e = 0; e < 14; e++) begin
      req      = tbl[e].req;
      req_data = tbl[e].data;
      wait_ack(ok);
      if (ok) begin
        chk($sformatf("v%0d_ack", e), {28'd0, ack}, 32'd1 << tbl[e].exp_gnt);
        chk($sformatf("v%0d_send", e), {31'd0, uart_send}, 32'd1);
        chk($sformatf("v%0d_busy", e), {31'd0, busy}, 32'd1);
        chk($sformatf("v%0d_gnt", e), {30'd0, grant_id}, {30'd0, tbl[e].exp_gnt});
        chk($sformatf("v%0d_tx", e), {24'd0, tx_data}, {24'd0, tbl[e].exp_byte});
        if (e > 0) chk($sformatf("v%0d_spacing", e), cyc - last, 32'd256);
        last = cyc;
      end
    end

    // Busy falls 255 cycles after SEND; with no requests everything holds.
    req = 4'b0000;
    wait_idle();
    chk("busy_fall", cyc - last, 32'd255);
    repeat (5) @(negedge sys_clk);
    chk("idle_ack", {28'd0, ack}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_tx_hold", {24'd0, tx_data}, 32'hA1);
    chk("idle_gnt_hold", {30'd0, grant_id}, 32'd1);

    // Late requester arriving mid-WAIT waits for the next IDLE cycle.
    req      = 4'b0001;
    req_data = 32'h00770055;
    wait_ack(ok);
    chk("late_first_ack", {28'd0, ack}, 32'd1);
    last = cyc;
    req  = 4'b0000;
    repeat (11) @(negedge sys_clk);
    req = 4'b0100;
    chk("late_tx_in_wait", {24'd0, tx_data}, 32'h55);
    chk("late_busy_in_wait", {31'd0, busy}, 32'd1);
    wait_ack(ok);
    chk("late_ack", {28'd0, ack}, 32'h4);
    chk("late_spacing", cyc - last, 32'd256);
    chk("late_tx", {24'd0, tx_data}, 32'h77);
    chk("late_gnt", {30'd0, grant_id}, 32'd2);

    // Reset pulse at cnt=100 of WAIT.
    req = 4'b0000;
    repeat (101) @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_send", {31'd0, uart_send}, 32'd0);
    chk("midrst_tx", {24'd0, tx_data}, 32'd0);
    chk("midrst_gnt", {30'd0, grant_id}, 32'd3);
    chk("midrst_ack", {28'd0, ack}, 32'd0);
    sys_rst  = 1'b0;
    rst_cyc  = cyc;
    req      = 4'b0001;
    req_data = 32'h00000055;
    wait_ack(ok);
    chk("postrst_latency", cyc - rst_cyc, 32'd1);
    chk("postrst_ack", {28'd0, ack}, 32'd1);
    chk("postrst_gnt", {30'd0, grant_id}, 32'd0);
    chk("postrst_tx", {24'd0, tx_data}, 32'h55);
    req = 4'b0000;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
